// File: rtl/bcd_pkg.sv
// Shared types and constants for the shared binary-to-BCD converter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam int unsigned BCD_DIGITS = 4;
    localparam int unsigned DIGIT_W    = 4;
    localparam int unsigned BCD_W      = BCD_DIGITS * DIGIT_W;
    localparam int unsigned MAX_VALUE  = 9999;

endpackage

// File: rtl/bcd_dabble_step.sv
// One double-dabble iteration: add 3 to every BCD nibble >= 5, then shift left by one.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to register the result.
module bcd_dabble_step
    import bcd_pkg::*;
#(
    parameter int unsigned NUM_BITS = 14
) (
    input  logic [BCD_W+NUM_BITS-1:0] i_vec,
    output logic [BCD_W+NUM_BITS-1:0] o_vec
);

    localparam int unsigned VEC_W = BCD_W + NUM_BITS;

    logic [VEC_W-1:0] w_adj;

    // Correct each digit so the following shift carries cleanly into the next decade.
    always_comb begin
        w_adj = i_vec;
        for (int d = 0; d < BCD_DIGITS; d++) begin
            if (i_vec[NUM_BITS + d*DIGIT_W +: DIGIT_W] >= DIGIT_W'(5)) begin
                w_adj[NUM_BITS + d*DIGIT_W +: DIGIT_W] =
                    i_vec[NUM_BITS + d*DIGIT_W +: DIGIT_W] + DIGIT_W'(3);
            end
        end
    end

    // The MSB falls off; values are bounded by MAX_VALUE so it is always zero.
    assign o_vec = w_adj << 1;

endmodule

// File: rtl/bcd_convert_arbiter.sv
// Round-robin shares one iterative binary-to-BCD converter between two requesters.
// Latency: ack one cycle after grant, result_valid NUM_BITS+1 cycles after grant.
// Backpressure: requests are only sampled in IDLE; busy is high while a conversion runs.
module bcd_convert_arbiter #(
    parameter int unsigned NUM_BITS  = 14,
    parameter int unsigned MAX_VALUE = bcd_pkg::MAX_VALUE
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req_0,
    input  logic [31:0] value_0,
    input  logic        req_1,
    input  logic [31:0] value_1,
    output logic        ack_0,
    output logic        ack_1,
    output logic        busy,
    output logic        result_valid,
    output logic        result_id,
    output logic        overflow,
    output logic [3:0]  mille,
    output logic [3:0]  hundreds,
    output logic [3:0]  tens,
    output logic [3:0]  ones
);

    import bcd_pkg::*;

    localparam int unsigned VEC_W = BCD_W + NUM_BITS;
    localparam int unsigned CNT_W = $clog2(NUM_BITS + 1);
    localparam logic [NUM_BITS-1:0] MAX_LOAD = NUM_BITS'(MAX_VALUE);

    state_t             r_state;
    state_t             w_next_state;
    logic               r_last_grant;
    logic [VEC_W-1:0]   r_shift;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_id;
    logic               r_ovf_hold;
    logic               r_ack_0;
    logic               r_ack_1;
    logic               r_result_valid;
    logic               r_result_id;
    logic               r_overflow;
    logic [DIGIT_W-1:0] r_mille;
    logic [DIGIT_W-1:0] r_hundreds;
    logic [DIGIT_W-1:0] r_tens;
    logic [DIGIT_W-1:0] r_ones;

    logic               w_grant_vld;
    logic               w_grant_id;
    logic [31:0]        w_sel_value;
    logic               w_sat;
    logic [NUM_BITS-1:0] w_load;
    logic [VEC_W-1:0]   w_step;
    logic               w_last_shift;

    bcd_dabble_step #(
        .NUM_BITS (NUM_BITS)
    ) u_step (
        .i_vec (r_shift),
        .o_vec (w_step)
    );

    assign w_last_shift = (r_state == ST_SHIFT) && (r_cnt == CNT_W'(1));

    // Next-state and arbitration: a tie goes to the requester not served last.
    always_comb begin
        w_next_state = r_state;
        w_grant_vld  = 1'b0;
        w_grant_id   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (req_0 || req_1) begin
                    w_grant_vld  = 1'b1;
                    w_next_state = ST_SHIFT;
                    if (req_0 && req_1) begin
                        w_grant_id = ~r_last_grant;
                    end else begin
                        w_grant_id = req_1;
                    end
                end
            end
            ST_SHIFT: begin
                if (r_cnt == CNT_W'(1)) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Operand mux and saturation; the compare uses the full 32-bit operand.
    always_comb begin
        w_sel_value = w_grant_id ? value_1 : value_0;
        w_sat       = (w_sel_value > MAX_VALUE);
        w_load      = w_sel_value[NUM_BITS-1:0];
        if (w_sat) begin
            w_load = MAX_LOAD;
        end
    end

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Converter datapath: load on grant, one dabble step per SHIFT cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_shift      <= '0;
            r_cnt        <= '0;
            r_id         <= 1'b0;
            r_ovf_hold   <= 1'b0;
            r_last_grant <= 1'b1;
        end else if (w_grant_vld) begin
            r_shift      <= {{BCD_W{1'b0}}, w_load};
            r_cnt        <= CNT_W'(NUM_BITS);
            r_id         <= w_grant_id;
            r_ovf_hold   <= w_sat;
            r_last_grant <= w_grant_id;
        end else if (r_state == ST_SHIFT) begin
            r_shift      <= w_step;
            r_cnt        <= r_cnt - CNT_W'(1);
        end
    end

    // Acks are registered so they appear in the first SHIFT cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_ack_0 <= 1'b0;
            r_ack_1 <= 1'b0;
        end else begin
            r_ack_0 <= w_grant_vld && !w_grant_id;
            r_ack_1 <= w_grant_vld &&  w_grant_id;
        end
    end

    // Result registers load on the edge into DONE and hold until the next one.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_result_valid <= 1'b0;
            r_result_id    <= 1'b0;
            r_overflow     <= 1'b0;
            r_mille        <= '0;
            r_hundreds     <= '0;
            r_tens         <= '0;
            r_ones         <= '0;
        end else begin
            r_result_valid <= w_last_shift;
            if (w_last_shift) begin
                r_result_id <= r_id;
                r_overflow  <= r_ovf_hold;
                r_mille     <= w_step[VEC_W-1             -: DIGIT_W];
                r_hundreds  <= w_step[VEC_W-1-DIGIT_W     -: DIGIT_W];
                r_tens      <= w_step[VEC_W-1-2*DIGIT_W   -: DIGIT_W];
                r_ones      <= w_step[VEC_W-1-3*DIGIT_W   -: DIGIT_W];
            end
        end
    end

    assign ack_0        = r_ack_0;
    assign ack_1        = r_ack_1;
    assign busy         = (r_state != ST_IDLE);
    assign result_valid = r_result_valid;
    assign result_id    = r_result_id;
    assign overflow     = r_overflow;
    assign mille        = r_mille;
    assign hundreds     = r_hundreds;
    assign tens         = r_tens;
    assign ones         = r_ones;

endmodule

// File: tb/tb_bcd_convert_arbiter.sv
// Self-checking bench for bcd_convert_arbiter: directed and random conversions
// compared against an arithmetic decimal-digit model, plus arbitration, hold,
// busy and mid-conversion reset behaviour.
module tb_bcd_convert_arbiter;

    localparam int NB = 14;

    logic        clock;
    logic        reset_n;
    logic        req_0;
    logic [31:0] value_0;
    logic        req_1;
    logic [31:0] value_1;
    logic        ack_0;
    logic        ack_1;
    logic        busy;
    logic        result_valid;
    logic        result_id;
    logic        overflow;
    logic [3:0]  mille;
    logic [3:0]  hundreds;
    logic [3:0]  tens;
    logic [3:0]  ones;

    int total = 0;
    int bad   = 0;

    logic [15:0] cur_d;
    logic        cur_id;
    logic        cur_ovf;

    bcd_convert_arbiter #(
        .NUM_BITS  (NB),
        .MAX_VALUE (9999)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .req_0        (req_0),
        .value_0      (value_0),
        .req_1        (req_1),
        .value_1      (value_1),
        .ack_0        (ack_0),
        .ack_1        (ack_1),
        .busy         (busy),
        .result_valid (result_valid),
        .result_id    (result_id),
        .overflow     (overflow),
        .mille        (mille),
        .hundreds     (hundreds),
        .tens         (tens),
        .ones         (ones)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Decimal digits of the saturated operand, by plain division.
    function automatic void ref_model(input logic [31:0] v, output logic [15:0] d, output logic o);
        int unsigned s;
        o = (v > 32'd9999);
        s = o ? 9999 : v;
        d = {4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_outs"}, {ack_0, ack_1, busy, result_valid, result_id, overflow,
                            mille, hundreds, tens, ones}, 32'd0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        req_0   = 1'b0;
        req_1   = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk_zero_outputs("reset");
        reset_n = 1'b1;
        cur_d   = '0;
        cur_id  = 1'b0;
        cur_ovf = 1'b0;
    endtask

    // Inputs for the grant are already driven; the next edge is the grant edge.
    task automatic expect_conv(input logic id, input logic [31:0] val, input bit drop);
        logic [15:0] d;
        logic        o;
        ref_model(val, d, o);
        tick();
        chk("ack_0_grant", ack_0, {31'd0, id == 1'b0});
        chk("ack_1_grant", ack_1, {31'd0, id == 1'b1});
        chk("busy_grant", busy, 1);
        if (drop) begin
            if (id) req_1 = 1'b0;
            else    req_0 = 1'b0;
        end
        for (int c = 2; c <= NB; c++) begin
            tick();
            chk("rv_early", result_valid, 0);
            chk("ack_quiet", {ack_0, ack_1}, 0);
            chk("hold_digits", {mille, hundreds, tens, ones}, cur_d);
            chk("busy_shift", busy, 1);
        end
        tick();
        chk("rv_done", result_valid, 1);
        chk("digits", {mille, hundreds, tens, ones}, d);
        chk("result_id", result_id, id);
        chk("overflow", overflow, o);
        chk("busy_done", busy, 1);
        cur_d   = d;
        cur_id  = id;
        cur_ovf = o;
        tick();
        chk("rv_idle", result_valid, 0);
        chk("busy_idle", busy, 0);
        chk("hold_idle", {mille, hundreds, tens, ones}, cur_d);
    endtask

    initial begin
        logic [31:0] v;
        logic [31:0] v0;
        logic [31:0] v1;
        logic        rid;
        logic [31:0] bnd [4];

        reset_n = 1'b0;
        req_0   = 1'b0;
        req_1   = 1'b0;
        value_0 = '0;
        value_1 = '0;
        cur_d   = '0;
        cur_id  = 1'b0;
        cur_ovf = 1'b0;
        #3;
        chk_zero_outputs("async_reset");
        do_reset();

        // Single request.
        req_0 = 1'b1; value_0 = 32'd1234;
        expect_conv(1'b0, 32'd1234, 1'b1);

        // Boundaries through requester 1.
        bnd[0] = 32'd0; bnd[1] = 32'd9999; bnd[2] = 32'd10000; bnd[3] = 32'hFFFF_FFFF;
        for (int i = 0; i < 4; i++) begin
            req_1 = 1'b1; value_1 = bnd[i];
            expect_conv(1'b1, bnd[i], 1'b1);
        end

        // req_1 raised during requester 0's SHIFT is ignored until IDLE.
        v0 = $urandom_range(0, 9999);
        v1 = $urandom;
        req_0 = 1'b1; value_0 = v0;
        tick();
        chk("busy_ign_ack0", ack_0, 1);
        req_0 = 1'b0;
        for (int c = 2; c <= NB; c++) begin
            if (c == 5) begin
                req_1 = 1'b1; value_1 = v1;
            end
            tick();
            chk("busy_ign_ack1", ack_1, 0);
            chk("busy_ign_busy", busy, 1);
            chk("busy_ign_hold", {mille, hundreds, tens, ones, 7'd0, result_id, 7'd0, overflow},
                {cur_d, 7'd0, cur_id, 7'd0, cur_ovf});
        end
        begin
            logic [15:0] d;
            logic        o;
            ref_model(v0, d, o);
            tick();
            chk("busy_ign_rv", result_valid, 1);
            chk("busy_ign_digits", {mille, hundreds, tens, ones}, d);
            chk("busy_ign_id", result_id, 0);
            cur_d = d; cur_id = 1'b0; cur_ovf = o;
        end
        tick();
        chk("busy_ign_idle", busy, 0);
        expect_conv(1'b1, v1, 1'b1);

        // Random single-requester conversions across value classes.
        for (int i = 0; i < 16; i++) begin
            case ($urandom_range(0, 3))
                0: v = $urandom_range(0, 9999);
                1: v = $urandom_range(9990, 10010);
                2: v = $urandom_range(0, 99);
                default: v = $urandom;
            endcase
            rid = 1'($urandom_range(0, 1));
            if (rid) begin req_1 = 1'b1; value_1 = v; end
            else     begin req_0 = 1'b1; value_0 = v; end
            expect_conv(rid, v, 1'b1);
        end

        // Simultaneous requests right after reset: requester 0 first, then 1 back-to-back.
        do_reset();
        req_0 = 1'b1; value_0 = 32'd42;
        req_1 = 1'b1; value_1 = 32'd907;
        expect_conv(1'b0, 32'd42, 1'b1);
        expect_conv(1'b1, 32'd907, 1'b1);

        // Fairness under continuous requests from both sides.
        req_0 = 1'b1;
        req_1 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            value_0 = $urandom;
            value_1 = $urandom_range(0, 9999);
            v = (i % 2 == 1) ? value_1 : value_0;
            expect_conv(1'(i % 2), v, 1'b0);
        end
        req_0 = 1'b0;
        req_1 = 1'b0;

        // Reset in the middle of SHIFT aborts the conversion.
        req_0 = 1'b1; value_0 = 32'd5678;
        tick();
        chk("midrst_ack", ack_0, 1);
        req_0 = 1'b0;
        repeat (6) tick();
        reset_n = 1'b0;
        #1;
        chk_zero_outputs("midrst");
        cur_d = '0; cur_id = 1'b0; cur_ovf = 1'b0;
        tick();
        reset_n = 1'b1;
        for (int c = 0; c < NB + 6; c++) begin
            tick();
            chk("midrst_quiet", {result_valid, ack_0, ack_1, busy}, 0);
        end
        v = $urandom_range(0, 9999);
        req_1 = 1'b1; value_1 = v;
        expect_conv(1'b1, v, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
